counter_overflow: RTL and testbench

COUNTER_OVERFLOW -- requirements
Module: counter_overflow

---
 rtl/counter_overflow_if.sv | 24 ++
 rtl/counter_overflow.sv | 98 +++++++++
 tb/tb_counter_overflow.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/counter_overflow_if.sv
// Bundles the limit input and the three registered outputs of counter_overflow.
// The master drives the limit; the slave (the counter block) drives the results.
interface counter_overflow_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_LIM;
  logic [WIDTH-1:0] o_COUNT;
  logic             o_OVERFLOW;
  logic             o_CLK;

  modport master (
    output i_LIM,
    input  o_COUNT,
    input  o_OVERFLOW,
    input  o_CLK
  );

  modport slave (
    input  i_LIM,
    output o_COUNT,
    output o_OVERFLOW,
    output o_CLK
  );
endinterface

// File: rtl/counter_overflow.sv
// Saturating overflow counter with a sticky flag, plus an independent
// free-running clock divider. Both sections share only the clock and reset.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_COUNT | counting elapsed edges, comparing the count against i_LIM
//   ST_OVF   | count reached the limit; count and flag hold until reset
module counter_overflow #(
  parameter int WIDTH    = 8,
  parameter int DIV_HALF = 2
) (
  input  logic              clk_slow,
  input  logic              i_RST,
  counter_overflow_if.slave bus
);

  localparam int DW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DIV_HALF - 1);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // One-bit encoding so the sticky flag is the state flop itself.
  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_OVF   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] count_inc;

  logic [DW-1:0]    div_q, div_d;
  logic             clk_q, clk_d;

  // Counter section: state register
  always_ff @(posedge clk_slow or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_COUNT;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // The increment only happens while count_q < i_LIM, so it can never wrap.
  assign count_inc = count_q + ONE;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      ST_COUNT: begin
        if (count_q >= bus.i_LIM) begin
          state_d = ST_OVF;
        end else begin
          count_d = count_inc;
          if (count_inc >= bus.i_LIM) begin
            state_d = ST_OVF;
          end
        end
      end
      ST_OVF: begin
        state_d = ST_OVF;
      end
      default: begin
        state_d = ST_COUNT;
        count_d = '0;
      end
    endcase
  end

  // Divider section: free-running, unaffected by the overflow state
  always_ff @(posedge clk_slow or posedge i_RST) begin
    if (i_RST) begin
      div_q <= '0;
      clk_q <= 1'b0;
    end else begin
      div_q <= div_d;
      clk_q <= clk_d;
    end
  end

  always_comb begin
    div_d = div_q;
    clk_d = clk_q;
    if (div_q == D_LAST) begin
      div_d = '0;
      clk_d = ~clk_q;
    end else begin
      div_d = div_q + {{(DW-1){1'b0}}, 1'b1};
    end
  end

  assign bus.o_COUNT    = count_q;
  assign bus.o_OVERFLOW = (state_q == ST_OVF);
  assign bus.o_CLK      = clk_q;

endmodule

// File: tb/tb_counter_overflow.sv
// Directed bench for counter_overflow (WIDTH=8, DIV_HALF=2): latency, sticky
// overflow, limit changes, async reset, saturation at 255 and divider output.
module tb_counter_overflow;

  logic clk_slow;
  logic i_RST;
  int   checks;
  int   errors;

  counter_overflow_if #(.WIDTH(8)) bus ();

  counter_overflow #(
    .WIDTH   (8),
    .DIV_HALF(2)
  ) dut (
    .clk_slow(clk_slow),
    .i_RST   (i_RST),
    .bus     (bus.slave)
  );

  initial clk_slow = 1'b0;
  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_slow);
    #1;
  endtask

  task automatic do_reset(input logic [7:0] lim);
    @(negedge clk_slow);
    i_RST = 1'b1;
    bus.i_LIM = lim;
    tick();
    @(negedge clk_slow);
    i_RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [7:0] exp_cnt [8];
    logic       exp_ovf [8];
    logic       exp_clk [8];

    checks = 0;
    errors = 0;
    i_RST = 1'b1;
    bus.i_LIM = 8'd0;

    // Reset held across edges: nothing moves, even with a zero limit.
    repeat (3) tick();
    chk("rst_count", 32'(bus.o_COUNT), 32'd0);
    chk("rst_ovf",   32'(bus.o_OVERFLOW), 32'd0);
    chk("rst_clk",   32'(bus.o_CLK), 32'd0);

    // Limit 2: count 1,2,2..., flag 0,1,1..., divided clock 0,1,1,0,0,1,1,0.
    exp_cnt = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    exp_ovf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_clk = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.i_LIM = 8'd2;
    @(negedge clk_slow);
    i_RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("lim2_count_e%0d", i + 1), 32'(bus.o_COUNT), 32'(exp_cnt[i]));
      chk($sformatf("lim2_ovf_e%0d", i + 1), 32'(bus.o_OVERFLOW), 32'(exp_ovf[i]));
      chk($sformatf("div_clk_e%0d", i + 1), 32'(bus.o_CLK), 32'(exp_clk[i]));
    end

    // Limit 0: overflow on the first edge, count stays 0.
    do_reset(8'd0);
    tick();
    chk("lim0_ovf",   32'(bus.o_OVERFLOW), 32'd1);
    chk("lim0_count", 32'(bus.o_COUNT), 32'd0);
    tick();
    chk("lim0_hold",  32'(bus.o_COUNT), 32'd0);

    // Limit lowered below the count, then raised again: flag stays sticky.
    do_reset(8'd5);
    repeat (3) tick();
    chk("lower_pre_count", 32'(bus.o_COUNT), 32'd3);
    chk("lower_pre_ovf",   32'(bus.o_OVERFLOW), 32'd0);
    bus.i_LIM = 8'd1;
    tick();
    chk("lower_ovf",   32'(bus.o_OVERFLOW), 32'd1);
    chk("lower_count", 32'(bus.o_COUNT), 32'd3);
    bus.i_LIM = 8'd200;
    repeat (5) tick();
    chk("raise_ovf",   32'(bus.o_OVERFLOW), 32'd1);
    chk("raise_count", 32'(bus.o_COUNT), 32'd3);

    // Async reset pulse between edges after 4 edges with limit 10.
    do_reset(8'd10);
    repeat (4) tick();
    chk("abort_pre_count", 32'(bus.o_COUNT), 32'd4);
    #2 i_RST = 1'b1;
    #1;
    chk("abort_count", 32'(bus.o_COUNT), 32'd0);
    chk("abort_clk",   32'(bus.o_CLK), 32'd0);
    chk("abort_ovf",   32'(bus.o_OVERFLOW), 32'd0);
    #2 i_RST = 1'b0;
    tick();
    chk("restart_count_e1", 32'(bus.o_COUNT), 32'd1);
    chk("restart_clk_e1",   32'(bus.o_CLK), 32'd0);
    tick();
    chk("restart_clk_e2",   32'(bus.o_CLK), 32'd1);
    repeat (7) tick();
    chk("restart_ovf_e9",   32'(bus.o_OVERFLOW), 32'd0);
    chk("restart_count_e9", 32'(bus.o_COUNT), 32'd9);
    tick();
    chk("restart_ovf_e10",   32'(bus.o_OVERFLOW), 32'd1);
    chk("restart_count_e10", 32'(bus.o_COUNT), 32'd10);

    // Async reset while the divided clock is high forces it low at once.
    do_reset(8'd10);
    repeat (3) tick();
    chk("midper_clk_pre", 32'(bus.o_CLK), 32'd1);
    chk("midper_cnt_pre", 32'(bus.o_COUNT), 32'd3);
    #2 i_RST = 1'b1;
    #1;
    chk("midper_clk", 32'(bus.o_CLK), 32'd0);
    chk("midper_cnt", 32'(bus.o_COUNT), 32'd0);
    #2 i_RST = 1'b0;
    tick();
    chk("midper_restart_clk", 32'(bus.o_CLK), 32'd0);
    tick();
    chk("midper_restart_clk2", 32'(bus.o_CLK), 32'd1);

    // Full-scale limit: overflow at edge 255, no wrap afterwards.
    do_reset(8'd255);
    repeat (254) tick();
    chk("max_ovf_e254",   32'(bus.o_OVERFLOW), 32'd0);
    chk("max_count_e254", 32'(bus.o_COUNT), 32'd254);
    tick();
    chk("max_ovf_e255",   32'(bus.o_OVERFLOW), 32'd1);
    chk("max_count_e255", 32'(bus.o_COUNT), 32'd255);
    repeat (45) tick();
    chk("max_ovf_e300",   32'(bus.o_OVERFLOW), 32'd1);
    chk("max_count_e300", 32'(bus.o_COUNT), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
